// File: rtl/fila_pkg.sv
// Shared definitions for the fila queue controller: FSM states, operation
// codes, queue geometry and a small grant-decoding helper.
package fila_pkg;

  localparam int FILA_DEPTH  = 8;
  localparam int FILA_DATA_W = 8;

  localparam logic OP_ENQ = 1'b0;
  localparam logic OP_DEQ = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENQ   = 3'd1,
    DEQ_A = 3'd2,
    DEQ_B = 3'd3,
    ACK   = 3'd4
  } fila_state_e;

  // Turn a granted client index into its one-hot acknowledge pattern.
  function automatic logic [1:0] client_onehot(input logic idx);
    if (idx) begin
      client_onehot = 2'b10;
    end else begin
      client_onehot = 2'b01;
    end
  endfunction

endpackage

// File: rtl/arbitro_2.sv
// Two-way request arbiter for fila_ctrl.
// FILA_CTRL_RR_EN defined  : round-robin; on contention the client not served
//                            last wins, pointer updated on every grant.
// FILA_CTRL_RR_EN undefined: fixed priority, client 0 always wins.
module arbitro_2 (
`ifdef FILA_CTRL_RR_EN
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic       grant_en,
`endif
  input  logic [1:0] req,
  output logic       gnt_vld,
  output logic       gnt_idx
);

`ifdef FILA_CTRL_RR_EN
  // Client that wins the next contention; 0 out of reset.
  logic prio_r;

  // Select a requester, using the pointer only when both are asking.
  always_comb begin
    gnt_vld = req[0] | req[1];
    if (req == 2'b11) begin
      gnt_idx = prio_r;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end else begin
      gnt_idx = 1'b0;
    end
  end

  // Hand priority to the other client after every grant, rejected or not.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      prio_r <= 1'b0;
    end else if (grant_en && gnt_vld) begin
      prio_r <= ~gnt_idx;
    end else begin
      prio_r <= prio_r;
    end
  end
`else
  // Fixed priority: client 0 wins whenever it requests.
  always_comb begin
    gnt_vld = req[0] | req[1];
    if (req[0]) begin
      gnt_idx = 1'b0;
    end else begin
      gnt_idx = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/fila_ctrl.sv
// Two-client sequencer for the 8-entry fila queue. Arbitrates requests,
// spaces the enqueue/dequeue strobes so only one queue operation is in
// flight, tracks occupancy locally and rejects overflow/underflow.
// Optional macro FILA_CTRL_RR_EN selects round-robin arbitration.
module fila_ctrl
  import fila_pkg::*;
#(
  parameter int DATA_W = FILA_DATA_W,
  parameter int DEPTH  = FILA_DEPTH
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic [DATA_W-1:0] wr_data_1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        count_out,
  output logic [DATA_W-1:0] q_data_in,
  output logic              q_enqueue,
  output logic              q_dequeue,
  input  logic [DATA_W-1:0] q_data_out
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  fila_state_e       state_r;
  logic              gnt_r;
  logic [1:0]        ack_r;
  logic              err_r;
  logic [DATA_W-1:0] rd_data_r;
  logic [3:0]        count_r;
  logic [DATA_W-1:0] q_data_in_r;
  logic              q_enqueue_r;
  logic              q_dequeue_r;

  logic              gnt_vld_s;
  logic              gnt_idx_s;
  logic              grant_en_s;
  logic              op_s;
  logic [DATA_W-1:0] wdata_s;

  assign grant_en_s = (state_r == IDLE);

  arbitro_2 u_arbitro_2 (
`ifdef FILA_CTRL_RR_EN
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .grant_en  (grant_en_s),
`endif
    .req       (req),
    .gnt_vld   (gnt_vld_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Route the granted client's operation and write data.
  always_comb begin
    if (gnt_idx_s) begin
      op_s    = op[1];
      wdata_s = wr_data_1;
    end else begin
      op_s    = op[0];
      wdata_s = wr_data_0;
    end
  end

  // Controller FSM: every output is set on the edge entering its cycle.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      gnt_r       <= 1'b0;
      ack_r       <= 2'b00;
      err_r       <= 1'b0;
      rd_data_r   <= '0;
      count_r     <= 4'd0;
      q_data_in_r <= '0;
      q_enqueue_r <= 1'b0;
      q_dequeue_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r       <= 2'b00;
          err_r       <= 1'b0;
          q_enqueue_r <= 1'b0;
          q_dequeue_r <= 1'b0;
          if (gnt_vld_s && grant_en_s) begin
            gnt_r <= gnt_idx_s;
            if (op_s == OP_ENQ) begin
              if (count_r == DEPTH_C) begin
                // Overflow: acknowledge with error in the grant cycle.
                ack_r   <= client_onehot(gnt_idx_s);
                err_r   <= 1'b1;
                state_r <= ACK;
              end else begin
                q_enqueue_r <= 1'b1;
                q_data_in_r <= wdata_s;
                state_r     <= ENQ;
              end
            end else begin
              if (count_r == 4'd0) begin
                // Underflow: rd_data is left as it was.
                ack_r   <= client_onehot(gnt_idx_s);
                err_r   <= 1'b1;
                state_r <= ACK;
              end else begin
                q_dequeue_r <= 1'b1;
                state_r     <= DEQ_A;
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ENQ: begin
          q_enqueue_r <= 1'b0;
          q_data_in_r <= '0;
          count_r     <= count_r + 4'd1;
          ack_r       <= client_onehot(gnt_r);
          err_r       <= 1'b0;
          state_r     <= ACK;
        end
        DEQ_A: begin
          // Queue loads data_out at this edge; next cycle it shifts.
          q_dequeue_r <= 1'b0;
          state_r     <= DEQ_B;
        end
        DEQ_B: begin
          rd_data_r <= q_data_out;
          count_r   <= count_r - 4'd1;
          ack_r     <= client_onehot(gnt_r);
          err_r     <= 1'b0;
          state_r   <= ACK;
        end
        ACK: begin
          ack_r   <= 2'b00;
          err_r   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack_r       <= 2'b00;
          err_r       <= 1'b0;
          q_enqueue_r <= 1'b0;
          q_dequeue_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_r;
  assign err       = err_r;
  assign rd_data   = rd_data_r;
  assign count_out = count_r;
  assign q_data_in = q_data_in_r;
  assign q_enqueue = q_enqueue_r;
  assign q_dequeue = q_dequeue_r;

endmodule

// File: doc/fila_ctrl.md
# fila_ctrl

Two-requester controller that sequences and shares the 8-entry `fila` queue. It accepts enqueue/dequeue requests from two clients and arbitrates between them. It issues correctly spaced `enqueue_in`/`dequeue_in` strobes, returns dequeued data with a one-cycle acknowledge, and rejects operations that would overflow or underflow the queue. It sits between the user-facing input logic and the `fila` instance in the top level.

## Interface
- `DATA_W`, 8: data width; matches the queue.
- `DEPTH`, 8: queue capacity; matches the queue.
- `clk_10KHz`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  2  request per client; bit i belongs to client i.
- `op`  in  2  operation per client; 0 = enqueue, 1 = dequeue.
- `wr_data_0`, `wr_data_1`  in  DATA_W  enqueue data per client.
- `ack`  out  2  one-hot, one-cycle completion pulse to the served client.
- `err`  out  1  high with `ack` when the operation was rejected.
- `rd_data`  out  DATA_W  dequeued byte; valid while `ack` is high for a dequeue.
- `count_out`  out  4  controller's occupancy count, 0..DEPTH.
- `q_data_in`  out  DATA_W  to the queue's `data_in`.
- `q_enqueue`  out  1  to the queue's `enqueue_in`.
- `q_dequeue`  out  1  to the queue's `dequeue_in`.
- `q_data_out`  in  DATA_W  from the queue's `data_out`.

## Operation
- All outputs are registered. While `reset` is low, every output is 0, the state is IDLE, the count is 0, and the round-robin pointer is 0.
- The top level drives the queue's active-high reset from `~reset`, so both blocks clear together. A reset asserted mid-operation aborts the operation with no `ack`.
- The occupancy count is tracked internally. The queue's `len_out` lags by one cycle and is not used.
- States:
  - IDLE: samples `req`. If any request is present, grant one client and latch its `op` and data. If the operation is legal, go to ENQ or DEQ_A. If it is illegal, go to ACK with `err` set: an enqueue with count = DEPTH, or a dequeue with count = 0.
  - ENQ: `q_enqueue` = 1 and `q_data_in` = latched data; count increments at exit. Next state is ACK.
  - DEQ_A: `q_dequeue` = 1. Next state is DEQ_B.
  - DEQ_B: `q_dequeue` = 0. At exit, capture `q_data_out` into `rd_data` and decrement count. Next state is ACK. In this cycle the queue performs its shift; `q_enqueue` must be 0.
  - ACK: `ack[granted]` = 1, plus `err` if the operation was rejected. Next state is IDLE.
- Only one queue operation is in flight. Enqueue and dequeue strobes are never overlapped or issued back-to-back.
- A client must drop `req` within its `ack` cycle. A `req` still high in the following IDLE cycle is a new request.
- A rejected operation leaves the queue and the count untouched.

## Timing
- Grant at edge E0.
  - Enqueue: `q_enqueue` is high over E0–E1; the queue writes at E1; `ack` is high over E1–E2; IDLE again at E2.
  - Dequeue: `q_dequeue` is high over E0–E1; the queue loads `data_out` at E1 and shifts at E2; `ack` and `rd_data` are valid over E2–E3; IDLE at E3.
  - Rejection: `ack` and `err` are high over E0–E1.
- Latency from grant to `ack`: enqueue 1 cycle, dequeue 2 cycles, rejection 0 cycles. Minimum spacing between grants: enqueue 3 cycles, dequeue 4 cycles.
- `rd_data` holds its last value after `ack` drops.
- Full boundary: a request at count 8 is rejected and count stays at 8.
- Empty boundary: a request at count 0 is rejected and `rd_data` is unchanged.

## Configuration
- `FILA_CTRL_RR_EN` defined: round-robin arbitration. When both clients request, the one not served last wins. The pointer updates on every grant, including rejected ones.
- `FILA_CTRL_RR_EN` undefined: fixed priority, client 0 always wins. The pointer logic is absent.

## Structure
- `fila_pkg` holds:
  - the state enum (IDLE, ENQ, DEQ_A, DEQ_B, ACK);
  - the constants `OP_ENQ` = 0 and `OP_DEQ` = 1;
  - the constants `FILA_DEPTH` = 8 and `FILA_DATA_W` = 8.
- Sub-module `arbitro_2`: two-way arbiter with a grant/last-winner pointer, containing the macro-controlled logic.
- `fila_ctrl` holds the FSM, the count, and the data latches.

## Test plan
- Reset, then client 0 enqueues 0x11, 0x22, 0x33, then dequeues three times:
  - `rd_data` returns 0x11, 0x22, 0x33 in order, each with `ack[0]` 2 cycles after grant;
  - `count_out` goes 3 → 0.
- Nine enqueues by client 1 (0x01..0x09): the first eight are acked with `err` = 0; the ninth gives `ack[1]` with `err` = 1 and `count_out` stays at 8.
- Dequeue on an empty queue: `ack` and `err` are high in the grant cycle, `q_dequeue` never rises, and `count_out` = 0.
- Both clients request continuously for four grants:
  - with `FILA_CTRL_RR_EN`, grants alternate 0, 1, 0, 1;
  - without it, all four grants go to client 0.
- Alternating enqueue and dequeue back-to-back: `q_enqueue` is never high in a DEQ_B cycle, and the queue contents match a reference model.
- `reset` pulled low during DEQ_A: all outputs go to 0 immediately, no `ack` is issued, and after release `count_out` = 0.
